// File: rtl/i_cache_pkg.sv
// Shared constants, FSM state type and fill-order helper for the i_cache block fill FSM.
package i_cache_pkg;
   localparam int BLOCK_WORDS = 8;
   localparam int OFFSET_W    = 3;
   localparam int CNT_W       = 4;
   localparam int MEM_LATENCY = 4;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   // Word index for the n-th transfer of a fill; wraps modulo the block size.
   function automatic logic [OFFSET_W-1:0] word_idx(input logic [OFFSET_W-1:0] start,
                                                    input logic [CNT_W-1:0]    n);
      return start + n[OFFSET_W-1:0];
   endfunction
endpackage

// File: rtl/i_cache_fill_cnt.sv
// CNT_W-bit up-counter with synchronous clear (priority) and count enable.
module i_cache_fill_cnt
   import i_cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/i_cache_fill_fsm.sv
// I-cache block fill FSM: issues 8 word reads per miss and writes returned words into the arrays.
// Define ICF_CWF_EN to request the critical (missing) word first with wrap-around order.
module i_cache_fill_fsm
   import i_cache_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic [15:0] memory_data,
   input  logic        memory_data_valid,
   output logic        fsm_busy,
   output logic        memory_read,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic        write_tag_array,
   output logic [2:0]  fill_word,
   output logic [15:0] fill_data
);
   fill_state_e         state_q, state_d;
   logic [11:0]         base_q, base_d;
   logic [OFFSET_W-1:0] start_off;
   logic [CNT_W-1:0]    req_cnt, rcv_cnt;
   logic                start_fill, req_en, rcv_en, last_word;
   logic [OFFSET_W-1:0] req_word, rcv_word;
   logic                unused_addr_lsb;

`ifdef ICF_CWF_EN
   logic [OFFSET_W-1:0] off_q, off_d;
   assign start_off       = off_q;
   assign unused_addr_lsb = miss_address[0];
`else
   assign start_off       = '0;
   assign unused_addr_lsb = ^miss_address[3:0];
`endif

   assign start_fill = (state_q == IDLE) && miss_detected;
   assign req_en     = (state_q == FILL) && (req_cnt < CNT_W'(BLOCK_WORDS));
   assign rcv_en     = (state_q == FILL) && memory_data_valid;
   assign last_word  = rcv_en && (rcv_cnt == CNT_W'(BLOCK_WORDS - 1));
   assign req_word   = word_idx(start_off, req_cnt);
   assign rcv_word   = word_idx(start_off, rcv_cnt);

   i_cache_fill_cnt u_req_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_fill),
      .en_i  (req_en),
      .cnt_o (req_cnt)
   );

   i_cache_fill_cnt u_rcv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (start_fill),
      .en_i  (rcv_en),
      .cnt_o (rcv_cnt)
   );

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
`ifdef ICF_CWF_EN
      off_d   = off_q;
`endif
      case (state_q)
         IDLE: begin
            if (miss_detected) begin
               state_d = FILL;
               base_d  = miss_address[15:4];
`ifdef ICF_CWF_EN
               off_d   = miss_address[3:1];
`endif
            end
         end
         FILL: begin
            // Completion follows the received-word count, so gapped data simply stretches FILL.
            if (last_word)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         base_q  <= '0;
`ifdef ICF_CWF_EN
         off_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
`ifdef ICF_CWF_EN
         off_q   <= off_d;
`endif
      end
   end

   // Data-path outputs are zeroed outside their strobe so idle/reset outputs read as 0.
   assign fsm_busy         = (state_q == FILL) || start_fill;
   assign memory_read      = req_en;
   assign memory_address   = req_en ? {base_q, req_word, 1'b0} : 16'h0000;
   assign write_data_array = rcv_en;
   assign write_tag_array  = last_word;
   assign fill_word        = rcv_en ? rcv_word : 3'd0;
   assign fill_data        = rcv_en ? memory_data : 16'h0000;
endmodule
